// File: rtl/rv_muldiv_if.sv
// Operand/result bundle between issue logic and the mul/div unit.
// Master drives start/funct3/operands; slave returns busy, done and Result.
interface rv_muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] Result;

    modport master (
        output start, funct3, SrcA, SrcB,
        input  busy, done, Result
    );

    modport slave (
        input  start, funct3, SrcA, SrcB,
        output busy, done, Result
    );
endinterface

// File: rtl/rv_muldiv.sv
// Iterative RV32M unit: shift-add multiply, restoring divide; done XLEN cycles after start
// (next cycle for div-by-zero / signed overflow); start is ignored while busy, nothing is queued.
module rv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    rv_muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q;
    logic [2:0]          op_q;
    logic                neg_q, neg_a_q;
    logic                busy_q, done_q;
    logic [XLEN-1:0]     result_q, result_d;

    // Incoming-operation decode, used only on the accepting edge.
    logic                a_signed, b_signed, sgn_a, sgn_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                is_div, div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;

    always_comb begin
        a_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
        sgn_a       = a_signed && bus.SrcA[XLEN-1];
        sgn_b       = b_signed && bus.SrcB[XLEN-1];
        mag_a       = sgn_a ? -bus.SrcA : bus.SrcA;
        mag_b       = sgn_b ? -bus.SrcB : bus.SrcB;
        is_div      = bus.funct3[2];
        div_zero    = is_div && (bus.SrcB == '0);
        div_ovf     = is_div && !bus.funct3[0] &&
                      (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcB == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = bus.funct3[1] ? bus.SrcA : '1;
        end else if (div_ovf) begin
            special_res = bus.funct3[1] ? '0 : bus.SrcA;
        end
    end

    // One iteration step plus the sign-corrected result it would produce.
    logic [XLEN:0]       sum, trial;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;

    always_comb begin
        sum   = '0;
        trial = '0;
        acc_d = acc_q;
        if (!op_q[2]) begin
            sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
            acc_d = {sum, acc_q[XLEN-1:1]};
        end else begin
            // Upper XLEN+1 bits of {rem, quo} << 1 minus the divisor.
            trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
            if (!trial[XLEN]) begin
                acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end

        prod = neg_q   ? -acc_d : acc_d;
        quo  = neg_q   ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem  = neg_a_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];

        case (op_q)
            3'b000:                 result_d = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quo;
            default:                result_d = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (bus.start) begin
                        op_q    <= bus.funct3;
                        neg_q   <= sgn_a ^ sgn_b;
                        neg_a_q <= sgn_a;
                        cnt_q   <= '0;
                        if (special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            // Multiply: low half holds multiplier. Divide: low half holds dividend.
                            acc_q   <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                            opb_q   <= is_div ? mag_b : mag_a;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= result_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Result = result_q;
endmodule

// File: tb/tb_rv_muldiv.sv
// Bench for rv_muldiv: directed vectors, literal expectations, and a cycle-level reference model.
module tb_rv_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rv_muldiv_if #(.XLEN(32)) bus ();
    rv_muldiv_if #(.XLEN(8))  bus8 ();

    rv_muldiv #(.XLEN(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
    rv_muldiv #(.XLEN(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural result from plain integer arithmetic on w-bit operands.
    function automatic logic [31:0] model(input int w, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      mask, ua, ub, sa, sb, r;
        logic [63:0] pu;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = a[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = b[w-1] ? ub - (longint'(1) << w) : ub;
        pu   = 64'(ua) * 64'(ub);
        case (f)
            3'd0: r = ua * ub;
            3'd1: r = (sa * sb) >>> w;
            3'd2: r = (sa * ub) >>> w;
            3'd3: r = longint'(pu >> w);
            3'd4: r = (ub == 0) ? -1 : (sa == -(longint'(1) << (w-1)) && sb == -1) ? sa : sa / sb;
            3'd5: r = (ub == 0) ? -1 : ua / ub;
            3'd6: r = (ub == 0) ? sa : (sa == -(longint'(1) << (w-1)) && sb == -1) ? 0 : sa % sb;
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Cycle-level reference for the 32-bit unit, advanced on each rising edge.
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_res = '0, m_pend = '0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_left = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_res = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (bus.start) begin
                m_pend = model(32, bus.funct3, bus.SrcA, bus.SrcB);
                if (is_special(bus.funct3, bus.SrcA, bus.SrcB)) begin
                    m_done = 1'b1; m_res = m_pend;
                end else begin
                    m_busy = 1'b1; m_left = 32;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy",   bus.busy,   m_busy);
            check("cyc_done",   bus.done,   m_done);
            check("cyc_result", bus.Result, m_res);
            check("busy_and_done", bus.busy & bus.done, 1'b0);
        end
    end

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input int lat);
        int k;
        int busy_n;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.SrcA = a; bus.SrcB = b;
        check({name, "_model"}, model(32, f, a, b), lit);
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.SrcA = $urandom; bus.SrcB = $urandom;
        k = 0; busy_n = 0;
        while (!bus.done && k < 100) begin
            if (bus.busy) busy_n++;
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_latency"}, k, lat);
        check({name, "_busy_cycles"}, busy_n, lat);
        check({name, "_result"}, bus.Result, lit);
    endtask

    initial begin
        int k;
        int done_n;
        bus.start = 1'b0; bus.funct3 = '0; bus.SrcA = '0; bus.SrcB = '0;
        bus8.start = 1'b0; bus8.funct3 = '0; bus8.SrcA = '0; bus8.SrcB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_result", bus.Result, 32'h0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_7_m3",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
        run_op("mulh_min",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32);
        run_op("mulhu_ones",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
        run_op("mulhsu_ones", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        run_op("mulh_m7_3",   3'b001, 32'hFFFF_FFF9,  32'd3,         32'hFFFF_FFFF, 32);
        run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32);
        run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32);
        run_op("div_7_m2",    3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
        run_op("rem_7_m2",    3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         32);
        run_op("divu_100_7",  3'b101, 32'd100,        32'd7,         32'd14,        32);
        run_op("remu_100_7",  3'b111, 32'd100,        32'd7,         32'd2,         32);
        run_op("divu_zero",   3'b101, 32'h1234,       32'd0,         32'hFFFF_FFFF, 0);
        run_op("remu_zero",   3'b111, 32'h1234,       32'd0,         32'h1234,      0);
        run_op("div_zero",    3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op("rem_zero",    3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 0);
        run_op("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
        run_op("mul_after_special", 3'b000, 32'd3,    32'd5,         32'd15,        32);

        // 8-bit instance: same quotient, shorter latency.
        @(negedge clk);
        bus8.start = 1'b1; bus8.funct3 = 3'b101; bus8.SrcA = 8'd100; bus8.SrcB = 8'd7;
        check("x8_model", model(8, 3'b101, 32'd100, 32'd7), 32'd14);
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        k = 0;
        while (!bus8.done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("x8_latency", k, 8);
        check("x8_result", 32'(bus8.Result), 32'd14);

        // start while busy is dropped, not queued.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.SrcA = 32'd3; bus.SrcB = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 10) begin
                bus.start = 1'b1; bus.funct3 = 3'b101; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
            end
            if (k == 11) bus.start = 1'b0;
        end
        check("ignored_start_latency", k, 32);
        check("ignored_start_result", bus.Result, 32'd15);

        // Reset mid-calculation aborts with no done pulse.
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.SrcA = 32'd3; bus.SrcB = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_result", bus.Result, 32'h0);
        done_n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) done_n++;
        end
        check("abort_no_done", done_n, 0);

        // rst and start on the same edge: start is dropped.
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.SrcA = 32'd9; bus.SrcB = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", bus.busy, 1'b0);
        check("rst_start_done", bus.done, 1'b0);
        done_n = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_n++;
        end
        check("rst_start_dropped", done_n, 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rv_muldiv.md
# rv_muldiv

Iterative RV32M multiply/divide execution unit, parametrised in operand width, for the next-generation datapath. It sits beside the ALU on the SrcA/SrcB buses. It accepts one operation per start pulse and computes it over multiple cycles using shift-add multiplication or restoring division. Completion is signalled with a one-cycle done pulse, and the result is held stable for the Result multiplexer. The controller stalls PC update while busy is high.

## Interface
- XLEN, 32: operand and result width; any value ≥ 4.
- CNT_W, $clog2(XLEN)+1: iteration counter width. Derived; not overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- funct3  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  in  XLEN  multiplicand / dividend; sampled with start.
- SrcB  in  XLEN  multiplier / divisor; sampled with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; Result is valid from this cycle on.
- Result  out  XLEN  registered result; held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE/DONE + start: latch funct3, operand signs and operand magnitudes. Signed ops (MULH, DIV, REM) treat both operands as signed. MULHSU treats SrcA as signed and SrcB as unsigned. All other ops are unsigned.
- Normal path: go to CALC and clear the counter.
- Special case, divide by zero (DIV/DIVU/REM/REMU with SrcB = 0): go straight to DONE.
  - Quotient is all ones.
  - Remainder is SrcA unchanged.
- Special case, signed overflow (DIV/REM with SrcA = 1 followed by XLEN-1 zeros and SrcB = all ones): go straight to DONE.
  - Quotient is SrcA.
  - Remainder is 0.
- CALC, multiply: each cycle, if multiplier LSB = 1, add the multiplicand magnitude into the upper half of a 2·XLEN accumulator. Then shift the accumulator right by 1, keeping the carry bit.
- CALC, divide: each cycle, shift {remainder, quotient} left by 1. Trial-subtract the divisor from the remainder. On no borrow, keep the difference and set the quotient LSB.
- Counter increments each CALC cycle. When the counter reaches XLEN-1, the current iteration completes and the state goes to DONE.
- On entry to DONE, Result is loaded with the sign-corrected value:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - Product sign = XOR of the operand signs (two's-complement negate the full 2·XLEN value).
  - Quotient sign = XOR of the operand signs.
  - Remainder sign = sign of the dividend.
- DONE without start: go to IDLE next cycle. Result is retained.
- start in CALC is ignored. It is not queued.
- A back-to-back start in DONE is accepted, and its done occurs XLEN cycles later.

## Timing
- Reset values: state IDLE, busy 0, done 0, Result 0, counter 0, accumulators 0.
- Let the start be accepted on edge E0 (normal path):
  - busy = 1 during the XLEN cycles following E0.
  - Result is written and done = 1 for exactly the cycle following edge E0+XLEN.
  - busy = 0 in that same cycle.
  - Latency is XLEN cycles from the accepting edge to done.
- Special cases: done = 1 in the cycle right after E0, and busy is never asserted.
- done and busy are never high together.
- SrcA, SrcB and funct3 may change freely after E0.
- rst asserted mid-CALC: the next edge forces the reset values. No done pulse is produced for the aborted op, and Result reads 0.
- rst and start on the same edge: rst wins, and start is dropped.

## Test plan
- MUL, SrcA=7, SrcB=0xFFFFFFFD -> Result 0xFFFFFFEB. done exactly 32 cycles after start; busy high for 32 cycles.
- MULH 0x80000000×0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM -> 0xFFFFFFFF.
- DIVU 100 / 7 -> 14, and REMU -> 2. Rerun with XLEN=8: 100/7 -> 14, done after 8 cycles.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF, and REMU -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM -> 0. done one cycle after start, busy never high.
- start MUL 3×5, pulse start again with DIVU at cycle 10, assert rst at cycle 20 of a second MUL -> first Result 15 at cycle 32 with the DIVU ignored. After rst: busy 0, done 0, Result 0 next cycle, and no done pulse.
